// File: rtl/add_round_key_if.sv
`default_nettype none
// ============================================================================
// Module   : add_round_key_if
// Purpose  : Valid/ready bus for the AES AddRoundKey stage. The out_parity
//            signal exists only when ADD_ROUND_KEY_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface add_round_key_if #(
    parameter int WIDTH = 128
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   state_in;
    logic [WIDTH-1:0]   key_exp;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   state_out;
`ifdef ADD_ROUND_KEY_PARITY_EN
    logic [WIDTH/8-1:0] out_parity;

    modport master (
        output in_valid, state_in, key_exp, out_ready,
        input  in_ready, out_valid, state_out, out_parity
    );
    modport slave (
        input  in_valid, state_in, key_exp, out_ready,
        output in_ready, out_valid, state_out, out_parity
    );
`else
    modport master (
        output in_valid, state_in, key_exp, out_ready,
        input  in_ready, out_valid, state_out
    );
    modport slave (
        input  in_valid, state_in, key_exp, out_ready,
        output in_ready, out_valid, state_out
    );
`endif
endinterface
`default_nettype wire

// File: rtl/add_round_key.sv
`default_nettype none
// ============================================================================
// Module   : add_round_key
// Purpose  : AES-128 AddRoundKey: registered state XOR round key behind a
//            valid/ready handshake. Optional macro ADD_ROUND_KEY_PARITY_EN
//            adds a registered per-byte even-parity output.
// Revision : 1.0 - initial release
// ============================================================================
module add_round_key #(
    parameter int WIDTH = 128
) (
    input  wire logic      clk,
    input  wire logic      rst,
    add_round_key_if.slave bus
);
    localparam int c_NBYTES = WIDTH / 8;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_state_out;
    logic               w_in_ready;
    logic               w_accept;
    logic [WIDTH-1:0]   w_result;

    // Output register may be refilled in the same cycle it is drained.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_result   = bus.state_in ^ bus.key_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_state_out <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_state_out <= w_result;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.state_out = r_state_out;

`ifdef ADD_ROUND_KEY_PARITY_EN
    logic [c_NBYTES-1:0] w_parity;
    logic [c_NBYTES-1:0] r_out_parity;

    for (genvar gi = 0; gi < c_NBYTES; gi++) begin : g_parity
        assign w_parity[gi] = ^w_result[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_parity <= '0;
        end else if (w_accept) begin
            r_out_parity <= w_parity;
        end
    end

    assign bus.out_parity = r_out_parity;
`endif
endmodule
`default_nettype wire

// File: tb/tb_add_round_key.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_round_key
// Purpose  : Self-checking bench for add_round_key against a byte-level
//            reference model of the handshake and XOR behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_round_key;
    localparam int c_WIDTH = 128;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic         m_valid;
    logic [127:0] m_state;

    add_round_key_if #(.WIDTH(c_WIDTH)) bus ();

    add_round_key #(.WIDTH(c_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference XOR built byte by byte, byte 0 being the most significant.
    function automatic logic [127:0] ref_xor(input logic [127:0] s, input logic [127:0] k);
        logic [127:0] r;
        byte unsigned sb, kb;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            sb = s[127 - 8*i -: 8];
            kb = k[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = sb ^ kb;
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_parity(input logic [127:0] v);
        logic [15:0] p;
        for (int i = 0; i < 16; i++)
            p[i] = ($countones(v[8*i +: 8]) % 2) == 1;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check in_ready, advance model and DUT, check outputs.
    task automatic step(input logic iv, input logic ordy, input logic [127:0] s,
                        input logic [127:0] k, input logic r, input string tag);
        rst           = r;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.state_in  = s;
        bus.key_exp   = k;
        #1;
        chk({tag, "_in_ready"}, {127'd0, bus.in_ready}, {127'd0, (!m_valid || ordy)});
        if (r) begin
            m_valid = 1'b0;
            m_state = '0;
        end else if (iv && (!m_valid || ordy)) begin
            m_valid = 1'b1;
            m_state = ref_xor(s, k);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, "_out_valid"}, {127'd0, bus.out_valid}, {127'd0, m_valid});
        chk({tag, "_state_out"}, bus.state_out, m_state);
`ifdef ADD_ROUND_KEY_PARITY_EN
        chk({tag, "_parity"}, {112'd0, bus.out_parity}, {112'd0, ref_parity(m_state)});
`endif
    endtask

    logic [127:0] fips_s, fips_k, fips_r, v, v2;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fips_s   = 128'h046681e5e0cb199a48f8d37a2806264c;
        fips_k   = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_r   = 128'ha49c7ff2689f352b6b5bea43026a5049;

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        bus.state_in  = fips_s;
        bus.key_exp   = fips_k;
        repeat (2) @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_state = '0;
        chk("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("reset_state_out", bus.state_out, 128'd0);
        chk("reset_in_ready", {127'd0, bus.in_ready}, 128'd1);
`ifdef ADD_ROUND_KEY_PARITY_EN
        chk("reset_parity", {112'd0, bus.out_parity}, 128'd0);
`endif

        // FIPS-197 round-1 vector.
        step(1'b1, 1'b1, fips_s, fips_k, 1'b0, "fips");
        chk("fips_literal", bus.state_out, fips_r);
        step(1'b0, 1'b1, '0, '0, 1'b0, "drain");
        chk("drain_keeps_state", bus.state_out, fips_r);

        // Identity, inversion and self-cancellation.
        v = rand128();
        step(1'b1, 1'b1, v, '0, 1'b0, "key_zero");
        chk("key_zero_identity", bus.state_out, v);
        v = rand128();
        step(1'b1, 1'b1, v, '1, 1'b0, "key_ones");
        chk("key_ones_invert", bus.state_out, ~v);
        v = rand128();
        step(1'b1, 1'b1, v, v, 1'b0, "self");
        chk("self_zero", bus.state_out, 128'd0);
`ifdef ADD_ROUND_KEY_PARITY_EN
        chk("self_parity_zero", {112'd0, bus.out_parity}, 128'd0);
`endif

        // Backpressure: a new vector waits while out_ready is low.
        step(1'b1, 1'b1, fips_s, fips_k, 1'b0, "bp_load");
        v  = rand128();
        v2 = rand128();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, v, v2, 1'b0, "bp_stall");
            chk("bp_hold", bus.state_out, fips_r);
            chk("bp_ready_low", {127'd0, bus.in_ready}, 128'd0);
        end
        step(1'b1, 1'b1, v, v2, 1'b0, "bp_release");
        chk("bp_new", bus.state_out, v ^ v2);
        step(1'b0, 1'b1, '0, '0, 1'b0, "bp_drain");

        // Back-to-back throughput.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, rand128(), rand128(), 1'b0, "thru");
        step(1'b0, 1'b1, '0, '0, 1'b0, "thru_drain");

        // Random handshake traffic.
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rand128(), rand128(), 1'b0, "rand");

        // Reset while a result is stalled.
        step(1'b1, 1'b1, rand128(), rand128(), 1'b0, "mr_load");
        step(1'b1, 1'b0, rand128(), rand128(), 1'b0, "mr_stall");
        step(1'b1, 1'b0, rand128(), rand128(), 1'b1, "mr_reset");
        chk("mr_state_cleared", bus.state_out, 128'd0);
        step(1'b1, 1'b1, fips_s, fips_k, 1'b0, "mr_after");
        chk("mr_after_result", bus.state_out, fips_r);
        step(1'b0, 1'b1, '0, '0, 1'b0, "mr_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/add_round_key.md
Name: add_round_key

Overview:
- AES-128 AddRoundKey stage: bitwise XOR of the 128-bit cipher state with the 128-bit round key.
- Result is held in an output register with a valid/ready handshake.
- Sits between MixColumns (or the initial input) and the next round's SubBytes, in both the AES-128 round datapath and the key-whitening step.
- Byte order: bits [127:120] are byte 0 (first state byte, column 0 row 0); the XOR itself is order-independent.

Parameters:
- WIDTH, 128, state/key width in bits; must be a multiple of 8; only 128 is supported for AES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  state_in/key_exp are valid this cycle
- in_ready  output  1  stage can accept a new input this cycle
- state_in  input  WIDTH  cipher state
- key_exp  input  WIDTH  expanded round key for this round
- out_valid  output  1  state_out holds a valid result
- out_ready  input  1  downstream accepts state_out this cycle
- state_out  output  WIDTH  registered state_in XOR key_exp
- out_parity  output  WIDTH/8  per-byte even parity of state_out (only when ADD_ROUND_KEY_PARITY_EN is defined)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset values:
  - out_valid = 0
  - state_out = 0
  - out_parity = 0
  - in_ready = 1 after the reset edge
- Arithmetic: state_out = state_in ^ key_exp, full width, bit-for-bit. No carries, no byte swapping.
- in_ready = !out_valid || out_ready (combinational). This allows full throughput: one result per cycle when out_ready is held high.
- Accept condition: in_valid && in_ready at a rising edge. On accept, the XOR result is registered into state_out and out_valid is set to 1.
- Latency: exactly 1 cycle from accept to out_valid = 1.
- Drain: if out_valid && out_ready and there is no accept, out_valid goes to 0 on the next edge. state_out keeps its last value (it is not cleared).
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and out_valid stays 1.
- Stall: out_valid && !out_ready means in_ready = 0. state_out and out_valid hold stable until out_ready is asserted, and any in_valid is ignored (not accepted) meanwhile.
- Inputs are sampled only on accept; changes to state_in/key_exp at other times have no effect.
- Reset mid-operation: a pending result is discarded and out_valid = 0 on the next edge, regardless of in_valid or out_ready.
- in_valid while rst is high is ignored.
- There is no internal state other than the output register and its valid flag.

Optional Feature:
- Macro ADD_ROUND_KEY_PARITY_EN.
- Defined:
  - out_parity[i] = XOR of the 8 bits of state_out byte i, with byte i = state_out[8*i+7:8*i] (LSB byte is index 0).
  - It is registered alongside state_out, follows the same accept, hold and reset rules, and is cleared to 0 on reset.
- Not defined: the out_parity port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: assert rst for 2 cycles → out_valid = 0, state_out = 0, in_ready = 1.
- FIPS-197 vector: state_in = 046681e5e0cb199a48f8d37a2806264c, key_exp = a0fafe1788542cb123a339392a6c7605, in_valid pulsed once, out_ready = 1 → one cycle later out_valid = 1 and state_out = a49c7ff2689f352b6b5bea43026a5049.
- Identity and inversion:
  - key_exp = 0 → state_out = state_in.
  - key_exp = all-ones → state_out = ~state_in.
  - state_in = key_exp → state_out = 0.
  - With the parity macro defined, out_parity = 0000 for the all-zero result.
- Backpressure: with out_valid = 1, hold out_ready = 0 for 3 cycles while in_valid = 1 with a different vector → in_ready = 0; state_out stays a49c7ff2689f352b6b5bea43026a5049; the new vector is accepted only in the cycle out_ready rises and appears on the next edge.
- Throughput: 4 back-to-back vectors with in_valid and out_ready held at 1 → 4 consecutive out_valid cycles, with results in order and each correct.
- Reset mid-operation: assert rst in the cycle out_valid = 1 and out_ready = 0 → out_valid = 0 and state_out = 0 on the next edge; the first accept after reset completes normally.
